// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF sweep sequencer.
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_MEASURE,
        ST_HOLD,
        ST_SEND
    } state_e;

    localparam int CFG_ACT_BIT  = 7;
    localparam int CFG_MODE_BIT = 6;
    localparam int CFG_WAIT_LSB = 0;
    localparam int CFG_WAIT_W   = 3;

    localparam int BYTES_PER_TRANS = 8;

    localparam logic MODE_SINGLE = 1'b0;
    localparam logic MODE_CONT   = 1'b1;

endpackage

// File: rtl/ro_puf_byte_ser.sv
// Streams a latched count word MSB byte first over a valid/ready link,
// with one idle cycle after every accepted byte.
module ro_puf_byte_ser
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] word,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             last_acc
);

    localparam int LEFT_W = $clog2(BYTES_PER_TRANS + 1);

    logic [CNT_W-1:0]  shift_q, shift_d;
    logic              valid_q, valid_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic              acc;

    always_comb begin
        shift_d  = shift_q;
        valid_d  = valid_q;
        left_d   = left_q;
        acc      = valid_q & tx_ready;
        last_acc = acc & (left_q == LEFT_W'(1));
        if (load) begin
            shift_d = word;
            valid_d = 1'b1;
            left_d  = LEFT_W'(BYTES_PER_TRANS);
        end else if (acc) begin
            shift_d = shift_q << 8;
            valid_d = 1'b0;
            left_d  = left_q - LEFT_W'(1);
        end else if (left_q != '0) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
            valid_q <= 1'b0;
            left_q  <= '0;
        end else begin
            shift_q <= shift_d;
            valid_q <= valid_d;
            left_q  <= left_d;
        end
    end

    assign tx_data  = shift_q[CNT_W-1 -: 8];
    assign tx_valid = valid_q;

endmodule

// File: rtl/ro_puf_sweep_ctrl.sv
// Sweeps the RO mux, gates the edge counter for a programmable window
// and streams each latched count to the UART transmitter.
module ro_puf_sweep_ctrl
    import ro_puf_pkg::*;
#(
    parameter int NUM_RO     = 256,
    parameter int SEL_W      = 8,
    parameter int CNT_W      = 64,
    parameter int WIN_SHIFT  = 10,
    parameter int SETTLE_CYC = 16,
    parameter int SYNC_CYC   = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_valid,
    input  logic [7:0]       cfg_data,
    output logic             ro_en,
    output logic [SEL_W-1:0] ro_sel,
    output logic             cnt_clr,
    output logic             cnt_en,
    input  logic [CNT_W-1:0] cnt_value,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             sweep_done
);

    // Wide enough for the longest window, 2^(WIN_SHIFT+7) cycles.
    localparam int CYC_W = WIN_SHIFT + 8;
    localparam logic [CYC_W-1:0] SETTLE_LAST = CYC_W'(SETTLE_CYC - 1);
    localparam logic [CYC_W-1:0] SYNC_LAST   = CYC_W'(SYNC_CYC - 1);
    localparam logic [SEL_W-1:0] SEL_LAST    = SEL_W'(NUM_RO - 1);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      sel_q, sel_d;
    logic [CYC_W-1:0]      cyc_q, cyc_d;
    logic                  mode_q, mode_d;
    logic [CFG_WAIT_W-1:0] wait_q, wait_d;
    logic                  abort_q, abort_d;
    logic                  done_q, done_d;
    logic [CYC_W-1:0]      win_len, win_last;
    logic                  cfg_act, cfg_stop, abort_now;
    logic                  ser_load, ser_last;
    logic                  cfg_unused;

    assign cfg_unused = ^cfg_data[5:3];

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        cyc_d     = cyc_q;
        mode_d    = mode_q;
        wait_d    = wait_q;
        abort_d   = abort_q;
        done_d    = 1'b0;
        ser_load  = 1'b0;
        cfg_act   = cfg_valid & cfg_data[CFG_ACT_BIT];
        cfg_stop  = cfg_valid & ~cfg_data[CFG_ACT_BIT];
        abort_now = abort_q | cfg_stop;
        win_len   = CYC_W'(1) << (int'(wait_q) + WIN_SHIFT);
        win_last  = win_len - CYC_W'(1);

        if (state_q != ST_IDLE && cfg_stop) begin
            abort_d = 1'b1;
        end

        unique case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (cfg_act) begin
                    mode_d  = cfg_data[CFG_MODE_BIT];
                    wait_d  = cfg_data[CFG_WAIT_LSB +: CFG_WAIT_W];
                    sel_d   = '0;
                    cyc_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cyc_q == SETTLE_LAST) begin
                    cyc_d   = '0;
                    state_d = ST_MEASURE;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_MEASURE: begin
                if (cyc_q == win_last) begin
                    cyc_d   = '0;
                    state_d = ST_HOLD;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_HOLD: begin
                if (cyc_q == SYNC_LAST) begin
                    cyc_d    = '0;
                    ser_load = 1'b1;
                    state_d  = ST_SEND;
                end else begin
                    cyc_d = cyc_q + CYC_W'(1);
                end
            end
            ST_SEND: begin
                if (ser_last) begin
                    abort_d = 1'b0;
                    if (abort_now) begin
                        state_d = ST_IDLE;
                    end else if (sel_q != SEL_LAST) begin
                        sel_d   = sel_q + SEL_W'(1);
                        state_d = ST_SETTLE;
                    end else begin
                        done_d = 1'b1;
                        if (mode_q == MODE_CONT) begin
                            sel_d   = '0;
                            state_d = ST_SETTLE;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sel_q   <= '0;
            cyc_q   <= '0;
            mode_q  <= MODE_SINGLE;
            wait_q  <= '0;
            abort_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cyc_q   <= cyc_d;
            mode_q  <= mode_d;
            wait_q  <= wait_d;
            abort_q <= abort_d;
            done_q  <= done_d;
        end
    end

    ro_puf_byte_ser #(
        .CNT_W(CNT_W)
    ) u_ser (
        .clk      (clk),
        .reset    (reset),
        .load     (ser_load),
        .word     (cnt_value),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .last_acc (ser_last)
    );

    assign ro_en      = (state_q == ST_SETTLE) | (state_q == ST_MEASURE);
    assign cnt_clr    = (state_q == ST_SETTLE);
    assign cnt_en     = (state_q == ST_MEASURE);
    assign ro_sel     = sel_q;
    assign busy       = (state_q != ST_IDLE);
    assign sweep_done = done_q;

endmodule

// File: tb/tb_ro_puf_sweep_ctrl.sv
// Directed, table-driven bench for ro_puf_sweep_ctrl.
module tb_ro_puf_sweep_ctrl;

    localparam int NUM_RO     = 4;
    localparam int SEL_W      = 2;
    localparam int CNT_W      = 64;
    localparam int WIN_SHIFT  = 2;
    localparam int SETTLE_CYC = 4;
    localparam int SYNC_CYC   = 4;
    localparam logic [63:0] BASE = 64'h0123456789ABCDEF;

    logic             clk;
    logic             reset;
    logic             cfg_valid;
    logic [7:0]       cfg_data;
    logic             ro_en;
    logic [SEL_W-1:0] ro_sel;
    logic             cnt_clr;
    logic             cnt_en;
    logic [CNT_W-1:0] cnt_value;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;
    logic             busy;
    logic             sweep_done;

    int checks = 0;
    int errors = 0;

    ro_puf_sweep_ctrl #(
        .NUM_RO     (NUM_RO),
        .SEL_W      (SEL_W),
        .CNT_W      (CNT_W),
        .WIN_SHIFT  (WIN_SHIFT),
        .SETTLE_CYC (SETTLE_CYC),
        .SYNC_CYC   (SYNC_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_valid  (cfg_valid),
        .cfg_data   (cfg_data),
        .ro_en      (ro_en),
        .ro_sel     (ro_sel),
        .cnt_clr    (cnt_clr),
        .cnt_en     (cnt_en),
        .cnt_value  (cnt_value),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counter model: distinct value per oscillator so ordering is visible.
    assign cnt_value = BASE + 64'(ro_sel);

    typedef struct {
        logic [7:0] cfg;
        int         w;
        int         lat;
        int         ntxn;
        int         ndone;
        int         stall_byte;
        int         inj_byte;
        logic [7:0] inj_cfg;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input int sel, input int i);
        logic [63:0] w;
        w = BASE + 64'(sel);
        return w[63-8*i -: 8];
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        int lat, nb, run, ndone, scnt, nclr;
        bit injd, timeout;
        int runs[$];
        cfg_valid = 1'b1;
        cfg_data  = v.cfg;
        tx_ready  = 1'b1;
        tick;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        lat = -1; nb = 0; run = 0; ndone = 0; scnt = 0; nclr = 0;
        injd = 1'b0; timeout = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            if (tx_valid && lat < 0) lat = n;
            if (cnt_clr) nclr++;
            if (cnt_en) begin
                run++;
            end else if (run > 0) begin
                runs.push_back(run);
                run = 0;
            end
            if (sweep_done) ndone++;
            if (!busy) begin
                timeout = 1'b0;
                break;
            end
            tx_ready = 1'b1;
            if (nb == v.stall_byte && scnt < 10 && (scnt > 0 || tx_valid)) begin
                tx_ready = 1'b0;
                scnt++;
                chk($sformatf("v%0d_stall_valid", id), tx_valid, 1);
                chk($sformatf("v%0d_stall_data", id), tx_data,
                    exp_byte((nb / 8) % NUM_RO, nb % 8));
            end
            if (tx_valid && tx_ready) begin
                if (nb == v.inj_byte && !injd) begin
                    cfg_valid = 1'b1;
                    cfg_data  = v.inj_cfg;
                    injd      = 1'b1;
                end
                chk($sformatf("v%0d_byte%0d", id, nb), tx_data,
                    exp_byte((nb / 8) % NUM_RO, nb % 8));
                chk($sformatf("v%0d_sel%0d", id, nb), ro_sel,
                    (nb / 8) % NUM_RO);
                nb++;
            end
            tick;
            cfg_valid = 1'b0;
            cfg_data  = 8'h00;
        end
        tx_ready = 1'b1;
        if (run > 0) runs.push_back(run);
        chk($sformatf("v%0d_timeout", id), timeout, 0);
        chk($sformatf("v%0d_latency", id), lat, v.lat);
        chk($sformatf("v%0d_nbytes", id), nb, 8 * v.ntxn);
        chk($sformatf("v%0d_ndone", id), ndone, v.ndone);
        chk($sformatf("v%0d_nclr", id), nclr, SETTLE_CYC * v.ntxn);
        chk($sformatf("v%0d_nwin", id), runs.size(), v.ntxn);
        foreach (runs[k])
            chk($sformatf("v%0d_win%0d", id, k), runs[k], v.w);
    endtask

    initial begin
        bit found;
        reset     = 1'b1;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        tx_ready  = 1'b1;
        repeat (5) tick;
        chk("reset_outs",
            {ro_en, ro_sel, cnt_clr, cnt_en, tx_data, tx_valid, sweep_done},
            0);
        chk("reset_busy", busy, 0);
        reset = 1'b0;
        tick;
        chk("idle_busy", busy, 0);

        cfg_valid = 1'b1;
        cfg_data  = 8'h03;
        tick;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        repeat (3) tick;
        chk("inactive_cfg_busy", busy, 0);
        chk("inactive_cfg_ro_en", ro_en, 0);

        // cfg, W, latency, txns, done pulses, stall byte, inject byte, inject cfg
        vecs[0] = '{8'h83, 32, 41, 4, 1, 2, -1, 8'h00};
        vecs[1] = '{8'hC0, 4, 13, 6, 1, -1, 42, 8'h00};
        vecs[2] = '{8'h80, 4, 13, 4, 1, -1, 3, 8'h87};
        vecs[3] = '{8'h82, 16, 25, 1, 0, -1, 7, 8'h00};
        vecs[4] = '{8'hB9, 8, 17, 4, 1, -1, -1, 8'h00};
        vecs[5] = '{8'h81, 8, 17, 2, 0, -1, 13, 8'h00};
        vecs[6] = '{8'h80, 4, 13, 4, 1, -1, -1, 8'h00};

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
            repeat (2) tick;
        end

        cfg_valid = 1'b1;
        cfg_data  = 8'h80;
        tick;
        cfg_valid = 1'b0;
        cfg_data  = 8'h00;
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if (ro_sel == 2'd1 && cnt_en) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        chk("rst_reach_measure", found, 1);
        reset = 1'b1;
        tick;
        chk("rst_cnt_en", cnt_en, 0);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ro_sel", ro_sel, 0);
        reset = 1'b0;
        tick;
        run_vec(vecs[6], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ro_puf_sweep_ctrl.md
Name: ro_puf_sweep_ctrl

Overview:
Sequencer for the ring-oscillator PUF datapath. It takes the configuration byte received over UART, sweeps the RO mux across all oscillators, and gates and clears the edge counter for a programmable window. Each latched count is streamed as 8 bytes, MSB first, to the UART transmitter. It sits between the UART RX/TX blocks and the RO array/counter in ro_puf_s7.

Parameters:
NUM_RO, 256, number of oscillators swept (power of 2)
SEL_W, 8, log2(NUM_RO)
CNT_W, 64, counter width; fixed at 8*BYTES_PER_TRANS
WIN_SHIFT, 10, measurement window = 2^(counter_wait+WIN_SHIFT) cycles
SETTLE_CYC, 16, cycles RO runs before counting (counter held clear)
SYNC_CYC, 4, cycles after counting stops before count is sampled (CDC settle)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cfg_valid  in  1  one-cycle strobe, cfg_data valid
cfg_data  in  8  [7] activate, [6] mode (0 single sweep, 1 continuous), [2:0] counter_wait
ro_en  out  1  enable selected oscillator
ro_sel  out  SEL_W  RO mux select
cnt_clr  out  1  synchronous counter clear
cnt_en  out  1  counter gate
cnt_value  in  CNT_W  synchronized counter value
tx_data  out  8  byte to UART TX
tx_valid  out  1  byte available
tx_ready  in  1  UART TX can accept
busy  out  1  not IDLE
sweep_done  out  1  one-cycle pulse at end of a sweep

Behaviour:
- Reset: all outputs 0. State IDLE. Abort flag 0. Config registers 0.
- States: IDLE, SETTLE, MEASURE, HOLD, SEND.
- IDLE: cfg_valid with cfg_data[7]=1 latches mode and counter_wait, sets ro_sel=0, and enters SETTLE next cycle. cfg_data[7]=0 in IDLE is ignored.
- SETTLE: ro_en=1. cnt_clr=1 for all SETTLE_CYC cycles. Then enter MEASURE.
- MEASURE: cnt_en=1 for exactly W=2^(counter_wait+WIN_SHIFT) cycles. ro_en stays 1.
- HOLD: cnt_en=0, ro_en=0, for SYNC_CYC cycles. On the last HOLD cycle, capture cnt_value into a CNT_W shift register. Then enter SEND.
- SEND: emit 8 bytes, shift[63:56] first.
  - tx_valid stays high with tx_data stable until tx_valid&tx_ready. The next byte is presented in the following cycle, so at most one byte transfers every 2 cycles.
  - After the 8th transfer:
    - ro_sel<NUM_RO-1: ro_sel+1, go to SETTLE.
    - ro_sel==NUM_RO-1: pulse sweep_done. If mode=1 and abort=0, ro_sel wraps to 0 and goes to SETTLE. Otherwise go to IDLE.
- Any cfg_valid while busy:
  - cfg_data[7]=0 sets abort. Abort takes effect at the next transaction boundary (after the 8th byte of the current count): go to IDLE, no sweep_done, abort cleared.
  - cfg_data[7]=1 is ignored; the active config is not changed mid-sweep.
- cfg_valid coinciding with the last byte transfer: abort is evaluated including that cycle's cfg.
- Window arithmetic: counter_wait 0..7 gives W from 2^WIN_SHIFT to 2^(WIN_SHIFT+7). The window counter is sized for the maximum W. No wrap on cnt_value is handled here.
- Reset mid-operation: immediate return to reset values. A partially sent transaction is dropped.
- Latency: cfg strobe to first tx_valid = 1 + SETTLE_CYC + W + SYNC_CYC cycles.

Decomposition:
- Package ro_puf_pkg:
  - state enum
  - CFG_ACT_BIT=7, CFG_MODE_BIT=6, CFG_WAIT_LSB=0/CFG_WAIT_W=3
  - BYTES_PER_TRANS=8
  - MODE_SINGLE/MODE_CONT constants
- One sub-module, ro_puf_byte_ser: loads CNT_W word, performs valid/ready byte handshake, reports last-byte-accepted.

Test Plan:
(Sim params NUM_RO=4, WIN_SHIFT=2, SETTLE_CYC=4, SYNC_CYC=4, tx_ready tied 1.)
1. Reset held 5 cycles -> all outputs 0, busy=0. cfg 0x03 in IDLE -> stays IDLE.
2. cfg 0x83, cnt_value model = 0x0123456789ABCDEF -> first tx_valid 41 cycles after strobe (1+4+32+4).
   - 32 consecutive cnt_en cycles.
   - Bytes 01,23,45,67,89,AB,CD,EF.
   - ro_sel steps 0..3, 32 bytes total.
   - sweep_done pulses once, then IDLE.
3. tx_ready low for 10 cycles during byte 3 -> tx_data holds 0x45 with tx_valid=1; no byte lost or duplicated.
4. cfg 0xC0 (continuous, W=4) -> after ro_sel=3 it wraps to 0 and sweep_done pulses. cfg 0x00 during ro_sel=1 -> ro_sel=1 finishes its 8 bytes, then IDLE, no sweep_done.
5. cfg 0x87 while busy -> counter_wait unchanged; window stays at the original value.
6. Reset asserted mid-MEASURE -> next cycle cnt_en=0, ro_en=0, tx_valid=0, busy=0. A new cfg starts again at ro_sel=0.
